// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - command encodings, states and transaction scripts for the PCF8563 sequencer
package rtc_pkg;

    localparam logic [2:0] OP_START     = 3'd0;
    localparam logic [2:0] OP_WRITE     = 3'd1;
    localparam logic [2:0] OP_READ_ACK  = 3'd2;
    localparam logic [2:0] OP_READ_NACK = 3'd3;
    localparam logic [2:0] OP_STOP      = 3'd4;

    localparam logic [7:0] REG_SECONDS = 8'h02;
    localparam logic [7:0] REG_MINUTES = 8'h03;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_RSP,
        ST_ABORT_STOP,
        ST_ABORT_WAIT
    } state_t;

    typedef enum logic {
        TXN_POLL,
        TXN_SET
    } txn_t;

    // Step indices; both scripts share START / device-write / register-pointer at 0..2.
    localparam logic [2:0] STEP_FIRST   = 3'd0;
    localparam logic [2:0] STEP_DEV_W   = 3'd1;
    localparam logic [2:0] STEP_REG     = 3'd2;
    localparam logic [2:0] STEP_RESTART = 3'd3;
    localparam logic [2:0] STEP_DEV_R   = 3'd4;
    localparam logic [2:0] STEP_RD_SEC  = 3'd5;
    localparam logic [2:0] STEP_RD_MIN  = 3'd6;
    localparam logic [2:0] STEP_SET_SEC = 3'd3;
    localparam logic [2:0] STEP_SET_MIN = 3'd4;

    function automatic logic [2:0] script_op(input txn_t txn, input logic [2:0] step);
        logic [2:0] op;
        op = OP_STOP;
        if (txn == TXN_POLL) begin
            case (step)
                STEP_FIRST, STEP_RESTART:        op = OP_START;
                STEP_DEV_W, STEP_REG, STEP_DEV_R: op = OP_WRITE;
                STEP_RD_SEC:                     op = OP_READ_ACK;
                STEP_RD_MIN:                     op = OP_READ_NACK;
                default:                         op = OP_STOP;
            endcase
        end else begin
            case (step)
                STEP_FIRST:                                          op = OP_START;
                STEP_DEV_W, STEP_REG, STEP_SET_SEC, STEP_SET_MIN:   op = OP_WRITE;
                default:                                             op = OP_STOP;
            endcase
        end
        return op;
    endfunction

endpackage

// File: rtl/rtc_poll_timer.sv
// rtl/rtc_poll_timer.sv - free-running poll divider with a one-deep pending flag
module rtc_poll_timer #(
    parameter int POLL_DIV = 50_000_000
) (
    input  logic sysclk,
    input  logic reset,
    input  logic clear,
    output logic pending
);

    localparam int CW = $clog2(POLL_DIV);

    logic [CW-1:0] count;
    logic          wrap;

    assign wrap = (count == CW'(POLL_DIV - 1));

    // A wrap coinciding with a poll start re-arms the flag so that tick is not lost.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            count   <= '0;
            pending <= 1'b0;
        end else begin
            count <= wrap ? '0 : count + CW'(1);
            if (wrap) begin
                pending <= 1'b1;
            end else if (clear) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rtc_i2c_sequencer.sv
// rtl/rtc_i2c_sequencer.sv - PCF8563 poll/set transaction sequencer driving a byte-level I2C engine
module rtc_i2c_sequencer
    import rtc_pkg::*;
#(
    parameter int         POLL_DIV = 50_000_000,
    parameter logic [6:0] DEV_ADDR = 7'h51
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       set_req,
    input  logic [7:0] set_sec,
    input  logic [7:0] set_min,
    output logic       set_ack,
    output logic       set_done,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [2:0] cmd_op,
    output logic [7:0] cmd_wdata,
    input  logic       rsp_valid,
    input  logic [7:0] rsp_rdata,
    input  logic       rsp_nack,
    output logic [6:0] second,
    output logic [6:0] minute,
    output logic       vl_flag,
    output logic       time_valid,
    output logic       err,
    output logic       busy
);

    localparam logic [7:0] ADDR_W = {DEV_ADDR, 1'b0};
    localparam logic [7:0] ADDR_R = {DEV_ADDR, 1'b1};

    state_t     state, state_nxt;
    txn_t       txn, txn_nxt;
    logic [2:0] step, step_nxt, step_adv;
    logic [7:0] sec_buf, sec_buf_nxt;
    logic [7:0] sec_wr, sec_wr_nxt;
    logic [7:0] min_wr, min_wr_nxt;
    logic [2:0] op_adv;
    logic [7:0] wdata_adv;
    logic       poll_pending, poll_start;

    logic       cmd_valid_nxt, set_ack_nxt, set_done_nxt, err_nxt, busy_nxt;
    logic [2:0] cmd_op_nxt;
    logic [7:0] cmd_wdata_nxt;
    logic [6:0] second_nxt, minute_nxt;
    logic       vl_flag_nxt, time_valid_nxt;

    function automatic logic [7:0] script_wdata(input txn_t t, input logic [2:0] s,
                                                input logic [7:0] sec, input logic [7:0] mn);
        logic [7:0] d;
        d = 8'h00;
        case (s)
            STEP_DEV_W: d = ADDR_W;
            STEP_REG:   d = REG_SECONDS;
            default:    d = 8'h00;
        endcase
        if (t == TXN_POLL && s == STEP_DEV_R)   d = ADDR_R;
        if (t == TXN_SET  && s == STEP_SET_SEC) d = sec;
        if (t == TXN_SET  && s == STEP_SET_MIN) d = mn;
        return d;
    endfunction

    rtc_poll_timer #(
        .POLL_DIV (POLL_DIV)
    ) u_poll_timer (
        .sysclk  (sysclk),
        .reset   (reset),
        .clear   (poll_start),
        .pending (poll_pending)
    );

    assign step_adv  = step + 3'd1;
    assign op_adv    = script_op(txn, step_adv);
    assign wdata_adv = script_wdata(txn, step_adv, sec_wr, min_wr);

    always_comb begin
        state_nxt      = state;
        txn_nxt        = txn;
        step_nxt       = step;
        sec_buf_nxt    = sec_buf;
        sec_wr_nxt     = sec_wr;
        min_wr_nxt     = min_wr;
        cmd_valid_nxt  = cmd_valid;
        cmd_op_nxt     = cmd_op;
        cmd_wdata_nxt  = cmd_wdata;
        second_nxt     = second;
        minute_nxt     = minute;
        vl_flag_nxt    = vl_flag;
        time_valid_nxt = time_valid;
        busy_nxt       = busy;
        set_ack_nxt    = 1'b0;
        set_done_nxt   = 1'b0;
        err_nxt        = 1'b0;
        poll_start     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (set_req || poll_pending) begin
                    state_nxt     = ST_ISSUE;
                    step_nxt      = STEP_FIRST;
                    cmd_valid_nxt = 1'b1;
                    cmd_op_nxt    = OP_START;
                    cmd_wdata_nxt = 8'h00;
                    busy_nxt      = 1'b1;
                    if (set_req) begin
                        txn_nxt     = TXN_SET;
                        set_ack_nxt = 1'b1;
                        sec_wr_nxt  = set_sec;
                        min_wr_nxt  = set_min;
                    end else begin
                        txn_nxt    = TXN_POLL;
                        poll_start = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (cmd_ready) begin
                    cmd_valid_nxt = 1'b0;
                    state_nxt     = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                if (rsp_valid) begin
                    if (cmd_op == OP_WRITE && rsp_nack) begin
                        state_nxt     = ST_ABORT_STOP;
                        cmd_valid_nxt = 1'b1;
                        cmd_op_nxt    = OP_STOP;
                        cmd_wdata_nxt = 8'h00;
                    end else if (cmd_op == OP_STOP) begin
                        state_nxt    = ST_IDLE;
                        busy_nxt     = 1'b0;
                        set_done_nxt = (txn == TXN_SET);
                    end else begin
                        // Seconds are parked until minutes arrive so the pair updates atomically.
                        if (cmd_op == OP_READ_ACK) begin
                            sec_buf_nxt = rsp_rdata;
                        end
                        if (cmd_op == OP_READ_NACK) begin
                            second_nxt     = sec_buf[6:0];
                            vl_flag_nxt    = sec_buf[7];
                            minute_nxt     = rsp_rdata[6:0];
                            time_valid_nxt = 1'b1;
                        end
                        step_nxt      = step_adv;
                        state_nxt     = ST_ISSUE;
                        cmd_valid_nxt = 1'b1;
                        cmd_op_nxt    = op_adv;
                        cmd_wdata_nxt = wdata_adv;
                    end
                end
            end
            ST_ABORT_STOP: begin
                if (cmd_ready) begin
                    cmd_valid_nxt = 1'b0;
                    state_nxt     = ST_ABORT_WAIT;
                end
            end
            ST_ABORT_WAIT: begin
                if (rsp_valid) begin
                    state_nxt = ST_IDLE;
                    busy_nxt  = 1'b0;
                    err_nxt   = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state      <= ST_IDLE;
            txn        <= TXN_POLL;
            step       <= STEP_FIRST;
            sec_buf    <= 8'h00;
            sec_wr     <= 8'h00;
            min_wr     <= 8'h00;
            cmd_valid  <= 1'b0;
            cmd_op     <= OP_STOP;
            cmd_wdata  <= 8'h00;
            second     <= 7'h00;
            minute     <= 7'h00;
            vl_flag    <= 1'b0;
            time_valid <= 1'b0;
            busy       <= 1'b0;
            set_ack    <= 1'b0;
            set_done   <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            txn        <= txn_nxt;
            step       <= step_nxt;
            sec_buf    <= sec_buf_nxt;
            sec_wr     <= sec_wr_nxt;
            min_wr     <= min_wr_nxt;
            cmd_valid  <= cmd_valid_nxt;
            cmd_op     <= cmd_op_nxt;
            cmd_wdata  <= cmd_wdata_nxt;
            second     <= second_nxt;
            minute     <= minute_nxt;
            vl_flag    <= vl_flag_nxt;
            time_valid <= time_valid_nxt;
            busy       <= busy_nxt;
            set_ack    <= set_ack_nxt;
            set_done   <= set_done_nxt;
            err        <= err_nxt;
        end
    end

endmodule

// File: tb/tb_rtc_i2c_sequencer.sv
// tb/tb_rtc_i2c_sequencer.sv - scoreboard bench for the PCF8563 transaction sequencer
module tb_rtc_i2c_sequencer;
    import rtc_pkg::*;

    localparam int P = 200;

    logic       sysclk = 1'b0;
    logic       reset = 1'b1;
    logic       set_req = 1'b0;
    logic [7:0] set_sec = 8'h00;
    logic [7:0] set_min = 8'h00;
    logic       cmd_ready = 1'b1;
    logic       rsp_valid = 1'b0;
    logic [7:0] rsp_rdata = 8'h00;
    logic       rsp_nack = 1'b0;
    logic       set_ack, set_done, cmd_valid, vl_flag, time_valid, err, busy;
    logic [2:0] cmd_op;
    logic [7:0] cmd_wdata;
    logic [6:0] second, minute;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int edge_n = 0;
    int ack_cnt = 0, done_cnt = 0, err_cnt = 0, acc_cnt = 0;
    int done_cyc = 0, rise_cyc = 0;
    int hold_ready = 0, rsp_delay = 0;
    bit nack_next_write = 0, junk_nack = 0, rdack_seen = 0, was_valid = 0, busy_prev = 0;
    logic [2:0]  held_op;
    logic [7:0]  held_wd;
    logic        pend_nack;
    logic [7:0]  pend_data;
    logic [14:0] tprev = '0;
    logic [10:0] exp_cmd[$];
    logic [7:0]  rd_q[$];

    rtc_i2c_sequencer #(
        .POLL_DIV (P),
        .DEV_ADDR (7'h51)
    ) dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .set_req    (set_req),
        .set_sec    (set_sec),
        .set_min    (set_min),
        .set_ack    (set_ack),
        .set_done   (set_done),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_nack   (rsp_nack),
        .second     (second),
        .minute     (minute),
        .vl_flag    (vl_flag),
        .time_valid (time_valid),
        .err        (err),
        .busy       (busy)
    );

    always #5 sysclk = ~sysclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic push_cmd(input logic [2:0] op, input logic [7:0] wd);
        exp_cmd.push_back({op, wd});
    endtask

    task automatic push_poll();
        push_cmd(OP_START, 8'h00);
        push_cmd(OP_WRITE, 8'hA2);
        push_cmd(OP_WRITE, 8'h02);
        push_cmd(OP_START, 8'h00);
        push_cmd(OP_WRITE, 8'hA3);
        push_cmd(OP_READ_ACK, 8'h00);
        push_cmd(OP_READ_NACK, 8'h00);
        push_cmd(OP_STOP, 8'h00);
    endtask

    task automatic push_set(input logic [7:0] s, input logic [7:0] m);
        push_cmd(OP_START, 8'h00);
        push_cmd(OP_WRITE, 8'hA2);
        push_cmd(OP_WRITE, 8'h02);
        push_cmd(OP_WRITE, s);
        push_cmd(OP_WRITE, m);
        push_cmd(OP_STOP, 8'h00);
    endtask

    task automatic clear_counts();
        ack_cnt = 0; done_cnt = 0; err_cnt = 0; acc_cnt = 0;
    endtask

    task automatic wait_edge(input int target);
        int b = 1500;
        while (edge_n != target && b > 0) begin
            @(negedge sysclk);
            b--;
        end
        check_eq("wait_edge", edge_n, target);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int b = budget;
        @(negedge sysclk);
        while ((busy || exp_cmd.size() != 0) && b > 0) begin
            @(negedge sysclk);
            b--;
        end
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_queue"}, exp_cmd.size(), 0);
    endtask

    task automatic start_set(input logic [7:0] s, input logic [7:0] m);
        set_sec = s;
        set_min = m;
        set_req = 1'b1;
        @(negedge sysclk);
        check_eq("set_ack", set_ack, 1);
        check_eq("start_valid", cmd_valid, 1);
        check_eq("start_op", cmd_op, OP_START);
        set_sec = 8'hEE;
        set_min = 8'hEE;
        set_req = 1'b0;
    endtask

    // Engine model: accepts commands, answers each one two cycles after acceptance.
    initial begin
        forever begin
            @(posedge sysclk);
            #1;
            rsp_valid = 1'b0;
            rsp_nack  = 1'b0;
            rsp_rdata = 8'h00;
            if (reset) begin
                rsp_delay = 0;
                was_valid = 0;
                cmd_ready = 1'b1;
            end else begin
                if (rsp_delay > 0) begin
                    rsp_delay--;
                    if (rsp_delay == 0) begin
                        rsp_valid = 1'b1;
                        rsp_nack  = pend_nack;
                        rsp_rdata = pend_data;
                    end
                end
                if (cmd_valid && was_valid) begin
                    check_eq("hold_op", cmd_op, held_op);
                    check_eq("hold_wdata", cmd_wdata, held_wd);
                end else if (cmd_valid) begin
                    held_op = cmd_op;
                    held_wd = cmd_wdata;
                end
                was_valid = cmd_valid;
                cmd_ready = (hold_ready == 0);
                if (cmd_valid && hold_ready > 0) hold_ready--;
                if (cmd_valid && cmd_ready) begin
                    logic [10:0] e;
                    acc_cnt++;
                    if (exp_cmd.size() == 0) begin
                        check_eq("cmd_unexpected", exp_cmd.size(), 1);
                    end else begin
                        e = exp_cmd.pop_front();
                        check_eq("cmd_op", cmd_op, e[10:8]);
                        if (e[10:8] == OP_WRITE) check_eq("cmd_wdata", cmd_wdata, e[7:0]);
                    end
                    pend_nack = 1'b0;
                    pend_data = 8'h00;
                    if (cmd_op == OP_WRITE && nack_next_write) begin
                        pend_nack = 1'b1;
                        nack_next_write = 0;
                    end else if (cmd_op != OP_WRITE && junk_nack) begin
                        pend_nack = 1'b1;
                    end
                    if (cmd_op == OP_READ_ACK || cmd_op == OP_READ_NACK) begin
                        if (rd_q.size() != 0) pend_data = rd_q.pop_front();
                    end
                    if (cmd_op == OP_READ_ACK) rdack_seen = 1;
                    rsp_delay = 2;
                end
            end
        end
    end

    // Monitor: pulse counters, edge numbering for poll ticks, end-of-transaction alignment.
    initial begin
        forever begin
            @(posedge sysclk);
            #1;
            cyc++;
            if (reset) begin
                edge_n = 0;
            end else begin
                edge_n++;
                if (set_ack) ack_cnt++;
                if (set_done) done_cnt++;
                if (err) err_cnt++;
                if (set_done || err) begin
                    check_eq("end_busy", busy, 0);
                    check_eq("end_busy_prev", busy_prev, 1);
                    done_cyc = cyc;
                end
                if (busy && !busy_prev) rise_cyc = cyc;
                if ({vl_flag, minute, second} != tprev) check_eq("time_with_valid", time_valid, 1);
            end
            busy_prev = busy;
            tprev = {vl_flag, minute, second};
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (4) @(negedge sysclk);
        check_eq("rst_cmd_valid", cmd_valid, 0);
        check_eq("rst_cmd_op", cmd_op, OP_STOP);
        check_eq("rst_cmd_wdata", cmd_wdata, 0);
        check_eq("rst_second", second, 0);
        check_eq("rst_minute", minute, 0);
        check_eq("rst_vl", vl_flag, 0);
        check_eq("rst_time_valid", time_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_set_ack", set_ack, 0);
        check_eq("rst_set_done", set_done, 0);
        check_eq("rst_err", err, 0);
        reset = 1'b0;

        // Set transaction alone
        wait_edge(10);
        clear_counts();
        push_set(8'h30, 8'h15);
        start_set(8'h30, 8'h15);
        wait_done("set", 200);
        check_eq("set_ack_cnt", ack_cnt, 1);
        check_eq("set_done_cnt", done_cnt, 1);
        check_eq("set_err_cnt", err_cnt, 0);
        check_eq("set_time_valid", time_valid, 0);
        check_eq("set_second", second, 0);
        check_eq("set_minute", minute, 0);

        // Poll whose device-address write is NACKed
        clear_counts();
        nack_next_write = 1;
        push_cmd(OP_START, 8'h00);
        push_cmd(OP_WRITE, 8'hA2);
        push_cmd(OP_STOP, 8'h00);
        wait_edge(P + 2);
        wait_done("nack", 200);
        check_eq("nack_err_cnt", err_cnt, 1);
        check_eq("nack_done_cnt", done_cnt, 0);
        check_eq("nack_time_valid", time_valid, 0);
        check_eq("nack_second", second, 0);

        // Full poll with a stalled START and NACK noise on non-write responses
        clear_counts();
        rd_q.push_back(8'h85);
        rd_q.push_back(8'h42);
        hold_ready = 10;
        junk_nack = 1;
        push_poll();
        wait_edge(2 * P + 2);
        wait_done("poll", 300);
        junk_nack = 0;
        check_eq("poll_second", second, 7'h05);
        check_eq("poll_minute", minute, 7'h42);
        check_eq("poll_vl", vl_flag, 1);
        check_eq("poll_time_valid", time_valid, 1);
        check_eq("poll_err_cnt", err_cnt, 0);
        check_eq("poll_acc_cnt", acc_cnt, 8);

        // Set and tick in the same IDLE cycle; a long stall lets a second tick land mid-set
        wait_edge(3 * P - 1);
        clear_counts();
        hold_ready = 250;
        push_set(8'h45, 8'h07);
        push_poll();
        rd_q.push_back(8'h17);
        rd_q.push_back(8'h59);
        start_set(8'h45, 8'h07);
        wait_done("both", 800);
        check_eq("both_gap", rise_cyc - done_cyc, 1);
        check_eq("both_ack_cnt", ack_cnt, 1);
        check_eq("both_done_cnt", done_cnt, 1);
        check_eq("both_second", second, 7'h17);
        check_eq("both_minute", minute, 7'h59);
        check_eq("both_vl", vl_flag, 0);
        repeat (20) @(negedge sysclk);
        check_eq("drop_busy", busy, 0);
        check_eq("drop_acc_cnt", acc_cnt, 14);

        // Reset while waiting for the READ_ACK response
        push_poll();
        rd_q.push_back(8'h33);
        rd_q.push_back(8'h44);
        rdack_seen = 0;
        wait_edge(5 * P);
        begin
            int b = 200;
            while (!rdack_seen && b > 0) begin
                @(negedge sysclk);
                b--;
            end
        end
        check_eq("rdack_reached", rdack_seen, 1);
        @(negedge sysclk);
        check_eq("busy_before_reset", busy, 1);
        reset = 1'b1;
        @(posedge sysclk);
        #2;
        check_eq("mid_rst_cmd_valid", cmd_valid, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_time_valid", time_valid, 0);
        check_eq("mid_rst_second", second, 0);
        @(negedge sysclk);
        reset = 1'b0;
        exp_cmd.delete();
        rd_q.delete();
        repeat (3) @(negedge sysclk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rtc_i2c_sequencer.md
# rtc_i2c_sequencer

Transaction sequencer for the PCF8563 real-time clock. It sits between a byte-level I2C master engine and the rest of the design. It owns the engine's command port and runs two transaction types on it: a periodic read of the seconds/minutes registers, and an on-demand time-set write. When both are pending, it arbitrates between them at transaction boundaries.

## Interface
Parameters:
- POLL_DIV, 50_000_000: sysclk cycles between poll ticks; legal range ≥ 16.
- DEV_ADDR, 7'h51: 7-bit RTC address. Write byte = 8'hA2, read byte = 8'hA3.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - sysclk, in, 1: system clock.
  - reset, in, 1: synchronous, active-high.
- Set request:
  - set_req, in, 1: level request to write the time; sampled in IDLE.
  - set_sec, in, 8: BCD seconds to write; captured when the set transaction is accepted.
  - set_min, in, 8: BCD minutes to write; captured alongside set_sec.
  - set_ack, out, 1: one-cycle pulse when a set request is accepted.
  - set_done, out, 1: one-cycle pulse when a set transaction completes without error.
- Engine command port:
  - cmd_valid, out, 1: a command is presented to the engine.
  - cmd_ready, in, 1: the engine accepts the command.
  - cmd_op, out, 3: command code (START, WRITE, READ_ACK, READ_NACK, STOP).
  - cmd_wdata, out, 8: write byte for WRITE commands.
- Engine response port:
  - rsp_valid, in, 1: one-cycle pulse; exactly one per accepted command.
  - rsp_rdata, in, 8: read byte; meaningful for READ_ACK and READ_NACK.
  - rsp_nack, in, 1: slave NACK; meaningful for WRITE.
- Time outputs:
  - second, out, 7: BCD seconds (read byte & 7'h7F).
  - minute, out, 7: BCD minutes.
  - vl_flag, out, 1: bit 7 of the seconds register (clock-integrity lost).
  - time_valid, out, 1: set by the first complete poll; cleared only by reset.
- Status:
  - err, out, 1: one-cycle pulse on an aborted transaction.
  - busy, out, 1: high while not in IDLE.

## Operation
- States: IDLE, ISSUE, WAIT_RSP, ABORT_STOP, ABORT_WAIT.
- Each transaction is a fixed script of steps, and a step index walks through it.
- Poll script: START, WRITE A2, WRITE 02, START, WRITE A3, READ_ACK (seconds), READ_NACK (minutes), STOP.
- Set script: START, WRITE A2, WRITE 02, WRITE set_sec, WRITE set_min, STOP.
- Only one command is outstanding at a time:
  - ISSUE holds cmd_valid and waits for cmd_ready.
  - WAIT_RSP waits for rsp_valid, then advances the step, or returns to IDLE after STOP.
- Poll tick:
  - A free-running counter wraps at POLL_DIV-1.
  - The wrap sets a one-deep poll_pending flag. A tick that arrives while poll_pending is already set is dropped.
  - poll_pending clears when a poll transaction starts.
- Arbitration in IDLE:
  - set_req has priority over poll_pending.
  - A transaction in flight is never pre-empted.
  - When a set is accepted: set_ack pulses, and set_sec/set_min are latched.
- Read capture on the minutes response:
  - second, minute and vl_flag update together, in the same cycle as the READ_NACK response.
  - time_valid is set in that same cycle.
  - The seconds byte is held internally until then, so the outputs never show a mixed old/new pair.
- NACK on any WRITE response:
  - Go to ABORT_STOP and issue STOP; ABORT_WAIT waits for its response; then return to IDLE.
  - err pulses when the STOP response arrives.
  - Time outputs are unchanged and set_done does not pulse.
  - A request that is still pending is not retried automatically; set_req is re-evaluated in IDLE.
- rsp_nack is ignored for START, READ and STOP.
- rsp_valid arriving outside WAIT_RSP or ABORT_WAIT is ignored.

## Timing
- Reset values:
  - State IDLE; cmd_valid=0; cmd_op=STOP; cmd_wdata=0.
  - second=0, minute=0, vl_flag=0, time_valid=0.
  - set_ack, set_done, err = 0; busy=0.
  - Poll counter = 0; poll_pending = 0.
- All outputs are registered.
- IDLE to first command: when a request is seen in IDLE at edge N, cmd_valid=1 from edge N+1 (START).
- Handshake: cmd_op and cmd_wdata stay stable while cmd_valid=1 and cmd_ready=0. cmd_valid drops the cycle after cmd_valid & cmd_ready.
- Next command: cmd_valid for the next step rises one cycle after rsp_valid.
- Transaction end: busy falls one cycle after the final STOP response. set_done or err pulses in that same cycle.
- Reset mid-transaction: everything returns to reset values at the next edge. No STOP is issued; the engine is reset by the same reset.
- set_req and a poll wrap arriving in the same cycle in IDLE: the set wins; poll_pending is still set and is served next.

## Structure
- Package rtc_pkg:
  - cmd_op encodings: START=0, WRITE=1, READ_ACK=2, READ_NACK=3, STOP=4.
  - RTC register addresses: SECONDS=8'h02, MINUTES=8'h03.
  - State enum and script step constants.
- Sub-module rtc_poll_timer: POLL_DIV counter plus the poll_pending flag. Inputs: clear (poll start). Output: pending.

## Test plan
- Poll with ACKing engine model returning 8'h85 then 8'h42:
  - Command sequence matches the poll script exactly.
  - second=7'h05, vl_flag=1, minute=7'h42; time_valid rises in the same cycle.
- set_req with set_sec=8'h30, set_min=8'h15:
  - set_ack pulses once.
  - WRITE bytes are A2, 02, 30, 15, then STOP.
  - set_done pulses; time outputs are unchanged.
- Engine NACKs WRITE A2 during a poll:
  - Next command is STOP.
  - err pulses after the STOP response; time_valid stays 0.
- cmd_ready held low for 10 cycles: cmd_op and cmd_wdata stay constant, and only one command is issued.
- set_req and poll tick arriving in the same IDLE cycle:
  - The set transaction runs first, immediately followed by the poll.
  - A second tick arriving during the set is dropped.
- Reset asserted during READ_ACK wait: the next cycle shows cmd_valid=0, busy=0 and time_valid=0.
